// File: rtl/pcie_tag_pkg.sv
// Shared types and defaults for the PCIe read-tag tracking path.
package pcie_tag_pkg;

  localparam int unsigned TAG_WIDTH_DEF = 8;
  localparam int unsigned LEN_WIDTH_DEF = 11;
  // Largest read request in DW (4 KB); lengths are encoded 1..MAX_RD_DW.
  localparam int unsigned MAX_RD_DW     = 1024;

  typedef struct packed {
    logic                     valid;
    logic [LEN_WIDTH_DEF-1:0] remaining;
  } tag_entry_t;

endpackage

// File: rtl/cpl_tag_tracker_if.sv
// Request/completion/return bundle between the TX/RX engines and the tag tracker.
interface cpl_tag_tracker_if #(
  parameter int unsigned TAG_WIDTH = 8,
  parameter int unsigned LEN_WIDTH = 11
);

  logic                 req_valid;
  logic [TAG_WIDTH-1:0] req_tag;
  logic [LEN_WIDTH-1:0] req_len_dw;
  logic                 cpl_valid;
  logic [TAG_WIDTH-1:0] cpl_tag;
  logic [LEN_WIDTH-1:0] cpl_len_dw;
  logic                 err_clr;
  logic [TAG_WIDTH-1:0] tag_ret;
  logic                 tag_ret_valid;
  logic [TAG_WIDTH:0]   outstanding;
  logic                 err_unexp;
  logic                 err_overrun;
  logic                 err_reuse;

  // Engine side: issues requests/completions, observes returns and errors.
  modport master (
    output req_valid, req_tag, req_len_dw, cpl_valid, cpl_tag, cpl_len_dw, err_clr,
    input  tag_ret, tag_ret_valid, outstanding, err_unexp, err_overrun, err_reuse
  );

  // Tracker side.
  modport slave (
    input  req_valid, req_tag, req_len_dw, cpl_valid, cpl_tag, cpl_len_dw, err_clr,
    output tag_ret, tag_ret_valid, outstanding, err_unexp, err_overrun, err_reuse
  );

endinterface

// File: rtl/tag_len_table.sv
// Per-tag {valid, remaining} register array. One read/modify port for completions,
// one write port for allocations. The entry type comes from pcie_tag_pkg, so
// LEN_WIDTH is expected to match LEN_WIDTH_DEF.
module tag_len_table
  import pcie_tag_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_alloc_valid,
  input  logic [TAG_WIDTH-1:0] i_alloc_tag,
  input  logic [LEN_WIDTH-1:0] i_alloc_len,
  input  logic                 i_cpl_valid,
  input  logic [TAG_WIDTH-1:0] i_cpl_tag,
  input  logic [LEN_WIDTH-1:0] i_cpl_len,
  output logic                 o_alloc_ok,
  output logic                 o_reuse,
  output logic                 o_unexp,
  output logic                 o_overrun,
  output logic                 o_retire
);

  localparam int unsigned Depth = 2 ** TAG_WIDTH;

  tag_entry_t r_table [Depth];

  tag_entry_t w_cpl_entry;
  logic       w_cpl_hit;
  logic       w_reuse;

  // Both ports read the pre-update table. A same-tag collision therefore resolves
  // itself: an invalid entry rejects the completion and accepts the allocation,
  // a valid entry rejects the allocation and accepts the completion, so the two
  // writes below never target the same entry in one cycle.
  assign w_cpl_entry = r_table[i_cpl_tag];
  assign w_cpl_hit   = i_cpl_valid & w_cpl_entry.valid;
  assign w_reuse     = i_alloc_valid & (r_table[i_alloc_tag].valid | (i_alloc_len == '0));

  assign o_unexp    = i_cpl_valid & ~w_cpl_entry.valid;
  assign o_overrun  = w_cpl_hit & (i_cpl_len > w_cpl_entry.remaining);
  // Overrun retires the tag too so it is not leaked from the pool.
  assign o_retire   = w_cpl_hit & (i_cpl_len >= w_cpl_entry.remaining);
  assign o_reuse    = w_reuse;
  assign o_alloc_ok = i_alloc_valid & ~w_reuse;

  // Table update: completion decrement/retire and allocation write at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      if (w_cpl_hit) begin
        if (o_retire) begin
          r_table[i_cpl_tag] <= '0;
        end else begin
          r_table[i_cpl_tag].remaining <= w_cpl_entry.remaining - i_cpl_len;
        end
      end
      if (o_alloc_ok) begin
        r_table[i_alloc_tag].valid     <= 1'b1;
        r_table[i_alloc_tag].remaining <= i_alloc_len;
      end
    end
  end

endmodule

// File: rtl/cpl_tag_tracker.sv
// Completion-side tag tracker: records request lengths, consumes CplD lengths,
// returns finished tags to the pool and flags protocol errors.
module cpl_tag_tracker
  import pcie_tag_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF
) (
  input logic         clk,
  input logic         rst_n,
  cpl_tag_tracker_if.slave bus
);

  localparam logic [TAG_WIDTH:0] OutMax = {1'b1, {TAG_WIDTH{1'b0}}};

  logic w_alloc_ok;
  logic w_reuse;
  logic w_unexp;
  logic w_overrun;
  logic w_retire;
  logic w_sat_hi;
  logic w_sat_lo;

  logic [TAG_WIDTH-1:0] r_tag_ret;
  logic                 r_tag_ret_valid;
  logic [TAG_WIDTH:0]   r_outstanding;
  logic                 r_err_unexp;
  logic                 r_err_overrun;
  logic                 r_err_reuse;

  tag_len_table #(
    .TAG_WIDTH (TAG_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_table (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_alloc_valid (bus.req_valid),
    .i_alloc_tag   (bus.req_tag),
    .i_alloc_len   (bus.req_len_dw),
    .i_cpl_valid   (bus.cpl_valid),
    .i_cpl_tag     (bus.cpl_tag),
    .i_cpl_len     (bus.cpl_len_dw),
    .o_alloc_ok    (w_alloc_ok),
    .o_reuse       (w_reuse),
    .o_unexp       (w_unexp),
    .o_overrun     (w_overrun),
    .o_retire      (w_retire)
  );

  // Counter saturation is reported through the matching error flag.
  assign w_sat_hi = w_alloc_ok & ~w_retire & (r_outstanding == OutMax);
  assign w_sat_lo = w_retire & ~w_alloc_ok & (r_outstanding == '0);

  // Tag return register: one strobe the cycle after the retiring completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_ret       <= '0;
      r_tag_ret_valid <= 1'b0;
    end else begin
      r_tag_ret_valid <= w_retire;
      if (w_retire) begin
        r_tag_ret <= bus.cpl_tag;
      end
    end
  end

  // In-flight counter; a same-cycle allocate and retire cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else if (w_alloc_ok && !w_retire && !w_sat_hi) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (w_retire && !w_alloc_ok && !w_sat_lo) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  // Sticky errors; a new error in the clear cycle wins over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_unexp   <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_reuse   <= 1'b0;
    end else begin
      r_err_unexp   <= w_unexp | w_sat_lo | (r_err_unexp & ~bus.err_clr);
      r_err_overrun <= w_overrun | (r_err_overrun & ~bus.err_clr);
      r_err_reuse   <= w_reuse | w_sat_hi | (r_err_reuse & ~bus.err_clr);
    end
  end

  assign bus.tag_ret       = r_tag_ret;
  assign bus.tag_ret_valid = r_tag_ret_valid;
  assign bus.outstanding   = r_outstanding;
  assign bus.err_unexp     = r_err_unexp;
  assign bus.err_overrun   = r_err_overrun;
  assign bus.err_reuse     = r_err_reuse;

endmodule

// File: tb/tb_cpl_tag_tracker.sv
// Bench for cpl_tag_tracker: directed scenarios plus random traffic, all compared
// every cycle against a tag-table reference model kept in plain arrays.
module tb_cpl_tag_tracker;

  localparam int NTags = 256;

  logic clk;
  logic rst_n;

  cpl_tag_tracker_if #(.TAG_WIDTH(8), .LEN_WIDTH(11)) bus ();

  cpl_tag_tracker #(
    .TAG_WIDTH (8),
    .LEN_WIDTH (11)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;
  int ret_seen;

  // Reference model state.
  bit m_valid [NTags];
  int m_rem   [NTags];
  int m_out;
  bit m_unexp;
  bit m_over;
  bit m_reuse;
  bit m_ret_v;
  int m_ret_tag;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NTags; i++) begin
      m_valid[i] = 1'b0;
      m_rem[i]   = 0;
    end
    m_out = 0; m_unexp = 0; m_over = 0; m_reuse = 0; m_ret_v = 0; m_ret_tag = 0;
  endtask

  task automatic check_all();
    check_eq("tag_ret_valid", 32'(bus.tag_ret_valid), 32'(m_ret_v));
    if (m_ret_v) check_eq("tag_ret", 32'(bus.tag_ret), 32'(m_ret_tag));
    check_eq("outstanding", 32'(bus.outstanding), 32'(m_out));
    check_eq("err_unexp", 32'(bus.err_unexp), 32'(m_unexp));
    check_eq("err_overrun", 32'(bus.err_overrun), 32'(m_over));
    check_eq("err_reuse", 32'(bus.err_reuse), 32'(m_reuse));
  endtask

  task automatic drive_idle();
    bus.req_valid = 0; bus.req_tag = 0; bus.req_len_dw = 0;
    bus.cpl_valid = 0; bus.cpl_tag = 0; bus.cpl_len_dw = 0;
    bus.err_clr   = 0;
  endtask

  // One clock: drive inputs, advance the model by the tracker rules, compare.
  task automatic cycle(input bit rv, input int rt, input int rl,
                       input bit cv, input int ct, input int cl, input bit clr);
    bit pre_cpl_valid, pre_req_valid, inc, dec, n_unexp, n_over, n_reuse;
    int pre_rem;
    bus.req_valid = rv; bus.req_tag = rt[7:0]; bus.req_len_dw = rl[10:0];
    bus.cpl_valid = cv; bus.cpl_tag = ct[7:0]; bus.cpl_len_dw = cl[10:0];
    bus.err_clr   = clr;
    pre_cpl_valid = m_valid[ct];
    pre_rem       = m_rem[ct];
    pre_req_valid = m_valid[rt];
    inc = 0; dec = 0; n_unexp = 0; n_over = 0; n_reuse = 0;
    m_ret_v = 0;
    if (cv) begin
      if (!pre_cpl_valid) begin
        n_unexp = 1;
      end else if (cl >= pre_rem) begin
        if (cl > pre_rem) n_over = 1;
        m_valid[ct] = 0; m_rem[ct] = 0;
        m_ret_v = 1; m_ret_tag = ct; dec = 1;
      end else begin
        m_rem[ct] = pre_rem - cl;
      end
    end
    if (rv) begin
      if (pre_req_valid || rl == 0) begin
        n_reuse = 1;
      end else begin
        m_valid[rt] = 1; m_rem[rt] = rl; inc = 1;
      end
    end
    if (inc && !dec) begin
      if (m_out == NTags) n_reuse = 1;
      else m_out++;
    end else if (dec && !inc) begin
      if (m_out == 0) n_unexp = 1;
      else m_out--;
    end
    m_unexp = n_unexp | (m_unexp & !clr);
    m_over  = n_over  | (m_over  & !clr);
    m_reuse = n_reuse | (m_reuse & !clr);
    @(posedge clk);
    #1;
    if (bus.tag_ret_valid) ret_seen++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clr_errs();
    cycle(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(1), $urandom_range(15), $urandom_range(8),
            $urandom_range(1), $urandom_range(15), $urandom_range(6),
            $urandom_range(7) == 0);
    end
  endtask

  initial begin
    total = 0; bad = 0; ret_seen = 0;
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    #2;
    check_all();
    #20;
    rst_n = 1'b1;

    // Single request and exact completion.
    cycle(1, 5, 16, 0, 0, 0, 0);
    check_eq("out_after_alloc5", 32'(bus.outstanding), 32'd1);
    cycle(0, 0, 0, 1, 5, 16, 0);
    check_eq("ret5_valid", 32'(bus.tag_ret_valid), 32'd1);
    check_eq("ret5_tag", 32'(bus.tag_ret), 32'd5);
    idle(1);

    // Split completion, back to back on the same tag.
    cycle(1, 7, 32, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 7, 8, 0);
    cycle(0, 0, 0, 1, 7, 8, 0);
    cycle(0, 0, 0, 1, 7, 16, 0);
    check_eq("ret7_tag", 32'(bus.tag_ret), 32'd7);
    idle(1);

    // Unexpected completion, then clear.
    cycle(0, 0, 0, 1, 9, 4, 0);
    check_eq("unexp9", 32'(bus.err_unexp), 32'd1);
    clr_errs();

    // Overrun retires the tag.
    cycle(1, 3, 4, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 3, 6, 0);
    check_eq("over3", 32'(bus.err_overrun), 32'd1);
    clr_errs();

    // Reuse leaves the original length in place.
    cycle(1, 2, 8, 0, 0, 0, 0);
    cycle(1, 2, 5, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 2, 5, 0);
    cycle(0, 0, 0, 1, 2, 3, 0);
    clr_errs();

    // Different-tag request and completion in one cycle.
    cycle(1, 11, 1, 0, 0, 0, 0);
    cycle(1, 10, 2, 1, 11, 1, 0);
    cycle(0, 0, 0, 1, 10, 0, 0);
    cycle(0, 0, 0, 1, 10, 2, 0);

    // Same-tag collisions: invalid entry then valid entry.
    cycle(1, 12, 3, 1, 12, 1, 0);
    cycle(1, 12, 7, 1, 12, 3, 0);
    clr_errs();

    // Zero-length request, and a new error in the clear cycle.
    cycle(1, 20, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 21, 1, 1);
    check_eq("unexp_over_clr", 32'(bus.err_unexp), 32'd1);
    clr_errs();

    // Fill all tags, then drain in reverse order.
    for (int t = 0; t < NTags; t++) cycle(1, t, 1, 0, 0, 0, 0);
    check_eq("out_peak", 32'(bus.outstanding), 32'd256);
    ret_seen = 0;
    for (int t = NTags - 1; t >= 0; t--) cycle(0, 0, 0, 1, t, 1, 0);
    check_eq("drain_returns", 32'(ret_seen), 32'd256);
    check_eq("out_drained", 32'(bus.outstanding), 32'd0);

    // Random traffic, asynchronous reset mid-stream, more random traffic.
    rand_traffic(300);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    drive_idle();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rand_traffic(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpl_tag_tracker.md
Name: cpl_tag_tracker

Overview:
Sits on the completion (RX) side of the PCIe read-request path and closes the tag loop opened by the tag pool.
- Records the requested DW length for each tag the TX engine issues.
- Decrements the remaining length as CplD TLPs arrive.
- Returns the tag to the pool (tag_ret/tag_ret_valid, one pulse per tag) when the last completion for that tag has been consumed.
- Flags protocol errors: unexpected tag, overrun, tag reuse.

Parameters:
TAG_WIDTH, 8, tag width; the table has 2**TAG_WIDTH entries.
LEN_WIDTH, 11, DW length width; max request is 1024 DW (4 KB), encoded 1..1024.

Ports:
clk  in  1  single clock domain
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  TX engine issued a MRd using req_tag this cycle
req_tag  in  TAG_WIDTH  tag taken from the pool
req_len_dw  in  LEN_WIDTH  requested length in DW; 0 is illegal
cpl_valid  in  1  one CplD TLP header accepted this cycle
cpl_tag  in  TAG_WIDTH  tag field of the completion
cpl_len_dw  in  LEN_WIDTH  payload DW of this completion
tag_ret  out  TAG_WIDTH  tag being returned to the pool
tag_ret_valid  out  1  single-cycle return strobe; no backpressure
outstanding  out  TAG_WIDTH+1  number of tags currently in flight
err_unexp  out  1  sticky: completion for a non-outstanding tag
err_overrun  out  1  sticky: cpl_len_dw > remaining for that tag
err_reuse  out  1  sticky: req_tag already outstanding, or req_len_dw == 0
err_clr  in  1  synchronous clear of all sticky errors

Behaviour:
- Reset (async assert, sync release):
  - all table entries: valid=0, remaining=0
  - tag_ret=0, tag_ret_valid=0, outstanding=0, all err_* = 0
- Table: per tag, {valid, remaining[LEN_WIDTH-1:0]}, registered.
- Allocate (req_valid):
  - entry <= {1, req_len_dw}; outstanding += 1
  - if the entry is already valid or req_len_dw==0: set err_reuse; leave the entry unchanged; do not count.
- Completion (cpl_valid), against the pre-update table entry:
  - entry not valid: err_unexp set; no other effect.
  - cpl_len_dw > remaining: err_overrun set; the entry is retired as if complete. This prevents a tag leak.
  - cpl_len_dw == remaining: entry valid<=0; tag_ret<=cpl_tag and tag_ret_valid<=1 next cycle; outstanding -= 1.
  - otherwise: remaining <= remaining - cpl_len_dw.
  - cpl_len_dw==0 on a valid entry: no change, no error.
- Latency: the completion cycle N produces tag_ret_valid at cycle N+1. At most one return per cycle.
- Back-to-back completions to the same tag on consecutive cycles must see the updated remaining (no read hazard; table written at the clock edge, read combinationally).
- Simultaneous req and cpl, different tags: both take effect; outstanding nets to +1-1=0.
- Simultaneous req and cpl, same tag:
  - The completion is evaluated against the pre-update entry.
  - If the entry was invalid: err_unexp is set; the allocation proceeds.
  - If the entry was valid: err_reuse is set; the completion proceeds normally.
- outstanding never wraps: saturates at 2**TAG_WIDTH and at 0. Either saturation event also sets err_unexp or err_reuse.
- err_clr has priority below a same-cycle new error: the error bit remains 1.
- Reset mid-operation: the table is discarded. The pool re-initialises independently, so no tags are returned.

Decomposition:
- Shared package pcie_tag_pkg:
  - TAG_WIDTH and LEN_WIDTH defaults
  - MAX_RD_DW=1024
  - tag_entry_t {valid, remaining}
- One sub-module: tag_len_table (register array with one read/modify port for completions and one write port for allocations, plus the same-tag collision ordering above).
- Top level holds the outstanding counter, the return register and the error flags.

Test Plan:
- Reset, alloc tag 5 len 16, cpl tag 5 len 16 -> tag_ret=5, tag_ret_valid=1 exactly one cycle later; outstanding 1->0.
- Alloc tag 7 len 32; cpl tag 7 len 8,8,16 on consecutive cycles -> single tag_ret=7 after the third; no errors.
- Cpl tag 9 never allocated -> err_unexp=1; tag_ret_valid stays 0; err_clr -> err_unexp=0.
- Alloc tag 3 len 4; cpl tag 3 len 6 -> err_overrun=1, tag_ret=3 returned, outstanding=0.
- Alloc tag 2 while tag 2 outstanding -> err_reuse=1; remaining unchanged; outstanding unchanged.
- Alloc all 256 tags len 1, then complete in reverse order, with req/cpl to different tags in the same cycle -> 256 returns, outstanding peaks at 256 and ends at 0; assert rst_n low mid-stream -> all outputs 0 asynchronously.
